// File: rtl/zeroriscy_register_file_mp_pkg.sv
// Shared constants, stage record type and address-width helper for the multi-port register file.
package zeroriscy_rf_pkg;

    localparam int RF_ADDR_W_FULL = 5;
    localparam int RF_ADDR_W_E    = 4;
    localparam int RF_DATA_W      = 32;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           addr;
        logic [RF_DATA_W-1:0] data;
    } rf_stage_t;

    function automatic int rf_addr_w(input bit rv32e);
        return rv32e ? RF_ADDR_W_E : RF_ADDR_W_FULL;
    endfunction

endpackage

// File: rtl/zeroriscy_register_file_mp_if.sv
// Read/write port bundle of the register file; master drives addresses and write data.
interface zeroriscy_register_file_mp_if #(
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_READ*5-1:0]           raddr_i;
    logic [NUM_READ*DATA_WIDTH-1:0]  rdata_o;
    logic [NUM_WRITE*5-1:0]          waddr_i;
    logic [NUM_WRITE*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_WRITE-1:0]            we_i;
    logic                            wr_pending_o;

    modport master (
        output raddr_i, waddr_i, wdata_i, we_i,
        input  rdata_o, wr_pending_o
    );

    modport slave (
        input  raddr_i, waddr_i, wdata_i, we_i,
        output rdata_o, wr_pending_o
    );
endinterface

// File: rtl/zeroriscy_register_file_mp_wr_stage.sv
// One write-port staging register; writes to x0 never become valid.
module zeroriscy_rf_wr_stage #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [4:0] ADDR_MASK  = 5'h1F
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_test_en,
    input  logic                  i_we,
    input  logic [4:0]            i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [4:0]            o_addr,
    output logic [DATA_WIDTH-1:0] o_data
);
    logic [4:0]            w_addr;
    logic                  w_accept;
    logic                  r_valid;
    logic [4:0]            r_addr;
    logic [DATA_WIDTH-1:0] r_data;

    assign w_addr   = i_addr & ADDR_MASK;
    assign w_accept = i_we && (w_addr != 5'd0);

    // Test mode opens the payload enable; valid still gates any effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= w_accept;
            if (w_accept || i_test_en) begin
                r_addr <= w_addr;
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
endmodule

// File: rtl/zeroriscy_register_file_mp.sv
// Flip-flop register file with NUM_WRITE staged write ports and NUM_READ combinational reads.
module zeroriscy_register_file_mp
    import zeroriscy_rf_pkg::*;
#(
    parameter int RV32E      = 0,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1,
    parameter int BYPASS     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic test_en_i,
    zeroriscy_register_file_mp_if.slave rf
);
    localparam int         AW        = rf_addr_w(RV32E != 0);
    localparam int         NREG      = 1 << AW;
    localparam logic [4:0] ADDR_MASK = 5'(NREG - 1);

    logic                  w_valid [NUM_WRITE];
    logic [4:0]            w_addr  [NUM_WRITE];
    logic [DATA_WIDTH-1:0] w_data  [NUM_WRITE];
    logic [DATA_WIDTH-1:0] r_mem   [NREG];
    logic [4:0]            w_raddr [NUM_READ];
    logic [DATA_WIDTH-1:0] w_rdata [NUM_READ];
    logic                  w_pending;

    for (genvar p = 0; p < NUM_WRITE; p++) begin : g_stage
        zeroriscy_rf_wr_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_MASK  (ADDR_MASK)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_test_en (test_en_i),
            .i_we      (rf.we_i[p]),
            .i_addr    (rf.waddr_i[5*p +: 5]),
            .i_data    (rf.wdata_i[DATA_WIDTH*p +: DATA_WIDTH]),
            .o_valid   (w_valid[p]),
            .o_addr    (w_addr[p]),
            .o_data    (w_data[p])
        );
    end

    // Ascending port loop: the last matching assignment, i.e. the highest port, wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                for (int p = 0; p < NUM_WRITE; p++) begin
                    if (w_valid[p] && (w_addr[p] == 5'(i))) r_mem[i] <= w_data[p];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_READ; r++) begin
            w_raddr[r] = rf.raddr_i[5*r +: 5] & ADDR_MASK;
            w_rdata[r] = r_mem[w_raddr[r][AW-1:0]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NUM_WRITE; p++) begin
                    if (w_valid[p] && (w_addr[p] == w_raddr[r])) w_rdata[r] = w_data[p];
                end
            end
            if (w_raddr[r] == 5'd0) w_rdata[r] = '0;
        end
    end

    for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
        assign rf.rdata_o[DATA_WIDTH*r +: DATA_WIDTH] = w_rdata[r];
    end

    always_comb begin
        w_pending = 1'b0;
        for (int p = 0; p < NUM_WRITE; p++) w_pending = w_pending | w_valid[p];
    end

    assign rf.wr_pending_o = w_pending;
endmodule
